// File: rtl/spi_seq_pkg.sv
// Shared types and helpers for the SPI transaction sequencer.
package spi_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StSend,
        StWaitRx,
        StWaitRdy,
        StHold,
        StGap
    } seq_state_e;

    localparam logic [7:0] FILL_BYTE_DEFAULT = 8'h00;

    // Bits needed to hold any value in 0..max_val.
    function automatic int unsigned len_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry an extra wrap bit.
module spi_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
    assign do_push = wr_en && (!full || do_pop);
    assign rd_data = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Multi-byte SPI transaction controller: frames chip select around a burst of byte
// handshakes with the byte-level master, buffering TX and RX data in FIFOs.
module spi_txn_sequencer
    import spi_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned MAX_LEN       = 16,
    parameter int unsigned CS_SETUP_CLKS = 2,
    parameter int unsigned CS_HOLD_CLKS  = 2,
    parameter int unsigned CS_IDLE_CLKS  = 2,
    parameter logic [7:0]  FILL_BYTE     = FILL_BYTE_DEFAULT,
    localparam int unsigned LW           = len_width(MAX_LEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    i_wr_byte,
    input  logic          i_wr_en,
    output logic          o_tx_full,
    input  logic          i_start,
    input  logic [LW-1:0] i_len,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_underrun,
    output logic          o_rx_overflow,
    input  logic          i_rd_en,
    output logic [7:0]    o_rd_byte,
    output logic          o_rx_empty,
    output logic [7:0]    o_m_tx_byte,
    output logic          o_m_tx_dv,
    input  logic          i_m_tx_ready,
    input  logic          i_m_rx_dv,
    input  logic [7:0]    i_m_rx_byte,
    output logic          o_spi_cs_n
);

    localparam int unsigned SetupHoldMax =
        (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
    localparam int unsigned CntMax =
        (SetupHoldMax > CS_IDLE_CLKS) ? SetupHoldMax : CS_IDLE_CLKS;
    localparam int unsigned CW = len_width(CntMax);
    localparam int unsigned FW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [LW-1:0] MaxLen    = LW'(MAX_LEN);
    localparam logic [CW-1:0] SetupClks = CW'(CS_SETUP_CLKS);
    localparam logic [CW-1:0] HoldClks  = CW'(CS_HOLD_CLKS);
    localparam logic [CW-1:0] IdleClks  = CW'(CS_IDLE_CLKS);
    localparam logic [CW-1:0] CntOne    = CW'(1);

    seq_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic [LW-1:0] remaining_q;
    logic          cs_n_q;
    logic          tx_dv_q;
    logic [7:0]    tx_byte_q;
    logic          done_q;
    logic          underrun_q;
    logic          overflow_q;

    logic          tx_empty;
    logic          tx_pop;
    logic [7:0]    tx_head;
    logic [FW-1:0] tx_count;
    logic          rx_full;
    logic          rx_push;
    logic          rx_drop;
    logic [FW-1:0] rx_count;
    logic          start_ok;
    logic          issue;
    logic          unused_fifo_counts;

    assign start_ok = i_start && (state_q == StIdle) && (i_len != '0) && (i_len <= MaxLen);

    // A byte goes out at the end of setup, from SEND, or straight from WAIT_RDY when
    // more bytes remain, so the master never waits an extra cycle for dv.
    assign issue = i_m_tx_ready &&
                   (((state_q == StSetup) && (cnt_q >= SetupClks)) ||
                    (state_q == StSend) ||
                    ((state_q == StWaitRdy) && (remaining_q != '0)));

    assign tx_pop  = issue && !tx_empty;
    assign rx_push = (state_q == StWaitRx) && i_m_rx_dv;
    assign rx_drop = rx_push && rx_full && !(i_rd_en && !o_rx_empty);

    assign unused_fifo_counts = ^{tx_count, rx_count};

    spi_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (i_wr_en),
        .wr_data (i_wr_byte),
        .rd_en   (tx_pop),
        .rd_data (tx_head),
        .full    (o_tx_full),
        .empty   (tx_empty),
        .count   (tx_count)
    );

    spi_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rx_push),
        .wr_data (i_m_rx_byte),
        .rd_en   (i_rd_en),
        .rd_data (o_rd_byte),
        .full    (rx_full),
        .empty   (o_rx_empty),
        .count   (rx_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            remaining_q <= '0;
            cs_n_q      <= 1'b1;
            tx_dv_q     <= 1'b0;
            tx_byte_q   <= '0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            tx_dv_q <= 1'b0;
            done_q  <= 1'b0;
            if (issue) begin
                tx_dv_q   <= 1'b1;
                tx_byte_q <= tx_empty ? FILL_BYTE : tx_head;
                if (tx_empty) underrun_q <= 1'b1;
            end
            if (rx_drop) overflow_q <= 1'b1;

            case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        remaining_q <= i_len;
                        underrun_q  <= 1'b0;
                        overflow_q  <= 1'b0;
                        cs_n_q      <= 1'b0;
                        cnt_q       <= CntOne;
                        state_q     <= StSetup;
                    end
                end
                StSetup: begin
                    if (cnt_q >= SetupClks) state_q <= issue ? StWaitRx : StSend;
                    else                    cnt_q   <= cnt_q + 1'b1;
                end
                StSend: begin
                    if (issue) state_q <= StWaitRx;
                end
                StWaitRx: begin
                    if (i_m_rx_dv) begin
                        remaining_q <= remaining_q - 1'b1;
                        state_q     <= StWaitRdy;
                    end
                end
                StWaitRdy: begin
                    if (i_m_tx_ready) begin
                        if (remaining_q != '0) begin
                            state_q <= StWaitRx;
                        end else begin
                            cnt_q   <= CntOne;
                            state_q <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (cnt_q >= HoldClks) begin
                        cs_n_q  <= 1'b1;
                        done_q  <= 1'b1;
                        cnt_q   <= CntOne;
                        state_q <= StGap;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StGap: begin
                    if (cnt_q >= IdleClks) state_q <= StIdle;
                    else                   cnt_q   <= cnt_q + 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_busy        = (state_q != StIdle);
    assign o_done        = done_q;
    assign o_underrun    = underrun_q;
    assign o_rx_overflow = overflow_q;
    assign o_m_tx_byte   = tx_byte_q;
    assign o_m_tx_dv     = tx_dv_q;
    assign o_spi_cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer with a loopback byte-master model.
module tb_spi_txn_sequencer;

    localparam int unsigned IDLE_CLKS   = 2;
    localparam int unsigned M_DELAY     = 3;
    // cs_n low time for the 2-byte loopback transaction with M_DELAY=3:
    // 2 setup + 5 cycles per byte (dv, 3 delay, rx_dv, ready) + 2 hold.
    localparam int unsigned CS_LOW_2B   = 14;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] i_wr_byte = '0;
    logic       i_wr_en = 1'b0;
    logic       o_tx_full;
    logic       i_start = 1'b0;
    logic [4:0] i_len = '0;
    logic       o_busy;
    logic       o_done;
    logic       o_underrun;
    logic       o_rx_overflow;
    logic       i_rd_en = 1'b0;
    logic [7:0] o_rd_byte;
    logic       o_rx_empty;
    logic [7:0] o_m_tx_byte;
    logic       o_m_tx_dv;
    logic       m_ready;
    logic       m_rx_dv;
    logic [7:0] m_rx_byte;
    logic       o_spi_cs_n;

    int checks = 0;
    int failures = 0;

    // Monitor/master state, updated on the falling edge.
    logic [7:0] tx_log [64];
    int         n_dv = 0;
    int         n_done = 0;
    int         cs_low = 0;
    int         gap_busy = 0;
    int         wait_cnt = 0;
    logic [7:0] pend = '0;

    spi_txn_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .i_wr_byte     (i_wr_byte),
        .i_wr_en       (i_wr_en),
        .o_tx_full     (o_tx_full),
        .i_start       (i_start),
        .i_len         (i_len),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_underrun    (o_underrun),
        .o_rx_overflow (o_rx_overflow),
        .i_rd_en       (i_rd_en),
        .o_rd_byte     (o_rd_byte),
        .o_rx_empty    (o_rx_empty),
        .o_m_tx_byte   (o_m_tx_byte),
        .o_m_tx_dv     (o_m_tx_dv),
        .i_m_tx_ready  (m_ready),
        .i_m_rx_dv     (m_rx_dv),
        .i_m_rx_byte   (m_rx_byte),
        .o_spi_cs_n    (o_spi_cs_n)
    );

    always #5 clk = ~clk;

    // Loopback master: drops ready after dv, returns the same byte M_DELAY cycles later.
    initial begin
        m_ready   = 1'b1;
        m_rx_dv   = 1'b0;
        m_rx_byte = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_ready  = 1'b1;
                m_rx_dv  = 1'b0;
                wait_cnt = 0;
            end else begin
                if (m_rx_dv) begin
                    m_rx_dv = 1'b0;
                    m_ready = 1'b1;
                end
                if (o_m_tx_dv) begin
                    tx_log[n_dv % 64] = o_m_tx_byte;
                    n_dv++;
                    m_ready  = 1'b0;
                    pend     = o_m_tx_byte;
                    wait_cnt = M_DELAY;
                end else if (wait_cnt > 0) begin
                    wait_cnt--;
                    if (wait_cnt == 0) begin
                        m_rx_dv   = 1'b1;
                        m_rx_byte = pend;
                    end
                end
            end
            if (o_done) n_done++;
            if (!o_spi_cs_n) cs_low++;
            if (o_spi_cs_n && o_busy) gap_busy++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        i_wr_byte = b;
        i_wr_en   = 1'b1;
        tick();
        i_wr_en   = 1'b0;
    endtask

    task automatic pop();
        i_rd_en = 1'b1;
        tick();
        i_rd_en = 1'b0;
    endtask

    task automatic start(input logic [4:0] len);
        i_len   = len;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (o_busy && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s: busy=%0b after timeout, required 0", tag, o_busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({o_spi_cs_n, o_m_tx_dv, o_busy, o_done, o_underrun, o_rx_overflow} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_ctrl: cs_n,dv,busy,done,ur,ovf=%b required 100000",
                     {o_spi_cs_n, o_m_tx_dv, o_busy, o_done, o_underrun, o_rx_overflow});
        end
        checks++;
        if (o_m_tx_byte !== 8'h00) begin
            failures++;
            $display("FAIL reset_tx_byte: got %h required 00", o_m_tx_byte);
        end
        checks++;
        if ({o_rx_empty, o_tx_full} !== 2'b10) begin
            failures++;
            $display("FAIL reset_fifo: rx_empty,tx_full=%b required 10", {o_rx_empty, o_tx_full});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int dv0, done0, cs0, gap0;
        dv0 = n_dv; done0 = n_done; cs0 = cs_low; gap0 = gap_busy;
        push(8'hA5);
        push(8'h3C);
        start(5'd2);
        wait_idle("basic_idle");
        checks++;
        if (n_dv - dv0 != 2) begin
            failures++;
            $display("FAIL basic_dv_count: got %0d required 2", n_dv - dv0);
        end
        checks++;
        if (tx_log[dv0 % 64] !== 8'hA5 || tx_log[(dv0 + 1) % 64] !== 8'h3C) begin
            failures++;
            $display("FAIL basic_tx_bytes: got %h %h required a5 3c",
                     tx_log[dv0 % 64], tx_log[(dv0 + 1) % 64]);
        end
        checks++;
        if (n_done - done0 != 1) begin
            failures++;
            $display("FAIL basic_done_count: got %0d required 1", n_done - done0);
        end
        checks++;
        if (cs_low - cs0 != CS_LOW_2B) begin
            failures++;
            $display("FAIL basic_cs_low: got %0d required %0d", cs_low - cs0, CS_LOW_2B);
        end
        checks++;
        if (gap_busy - gap0 != IDLE_CLKS) begin
            failures++;
            $display("FAIL basic_gap: got %0d required %0d", gap_busy - gap0, IDLE_CLKS);
        end
        checks++;
        if (o_rx_empty !== 1'b0 || o_rd_byte !== 8'hA5) begin
            failures++;
            $display("FAIL basic_rx0: empty=%b byte=%h required 0 a5", o_rx_empty, o_rd_byte);
        end
        pop();
        checks++;
        if (o_rd_byte !== 8'h3C) begin
            failures++;
            $display("FAIL basic_rx1: got %h required 3c", o_rd_byte);
        end
        pop();
        checks++;
        if (o_rx_empty !== 1'b1) begin
            failures++;
            $display("FAIL basic_rx_drained: empty=%b required 1", o_rx_empty);
        end
    endtask

    task automatic test_underrun();
        int dv0;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h5E; exp_b[1] = 8'h00; exp_b[2] = 8'h00;
        dv0 = n_dv;
        push(8'h5E);
        start(5'd3);
        wait_idle("ur_idle");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tx_log[(dv0 + i) % 64] !== exp_b[i]) begin
                failures++;
                $display("FAIL ur_byte%0d: got %h required %h", i, tx_log[(dv0 + i) % 64], exp_b[i]);
            end
        end
        checks++;
        if (o_underrun !== 1'b1) begin
            failures++;
            $display("FAIL ur_flag_set: got %b required 1", o_underrun);
        end
        repeat (3) pop();
        push(8'h66);
        start(5'd1);
        checks++;
        if (o_underrun !== 1'b0) begin
            failures++;
            $display("FAIL ur_flag_clear: got %b required 0", o_underrun);
        end
        wait_idle("ur_idle2");
        checks++;
        if (o_underrun !== 1'b0 || o_rd_byte !== 8'h66) begin
            failures++;
            $display("FAIL ur_clean_txn: ur=%b rx=%h required 0 66", o_underrun, o_rd_byte);
        end
        pop();
    endtask

    task automatic test_bad_len();
        int dv0, cs0, busy_seen;
        logic [4:0] lens [2];
        lens[0] = 5'd0; lens[1] = 5'd17;
        for (int k = 0; k < 2; k++) begin
            dv0 = n_dv; cs0 = cs_low; busy_seen = 0;
            start(lens[k]);
            for (int c = 0; c < 8; c++) begin
                if (o_busy) busy_seen++;
                tick();
            end
            checks++;
            if (busy_seen != 0 || n_dv != dv0 || cs_low != cs0) begin
                failures++;
                $display("FAIL bad_len_%0d: busy=%0d dv=%0d cs_low=%0d required 0 0 0",
                         lens[k], busy_seen, n_dv - dv0, cs_low - cs0);
            end
        end
    endtask

    task automatic test_rx_overflow();
        int dv0;
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
        checks++;
        if (o_tx_full !== 1'b1) begin
            failures++;
            $display("FAIL ovf_tx_full: got %b required 1", o_tx_full);
        end
        push(8'hEE);
        dv0 = n_dv;
        start(5'd16);
        wait_idle("ovf_fill_idle");
        checks++;
        if (n_dv - dv0 != 16 || tx_log[(dv0 + 15) % 64] !== 8'h1F) begin
            failures++;
            $display("FAIL ovf_fill: dv=%0d last=%h required 16 1f",
                     n_dv - dv0, tx_log[(dv0 + 15) % 64]);
        end
        checks++;
        if (o_rx_overflow !== 1'b0 || o_underrun !== 1'b0) begin
            failures++;
            $display("FAIL ovf_exact_fit: ovf=%b ur=%b required 0 0", o_rx_overflow, o_underrun);
        end
        dv0 = n_dv;
        push(8'h77);
        start(5'd1);
        wait_idle("ovf_idle");
        checks++;
        if (o_rx_overflow !== 1'b1 || tx_log[dv0 % 64] !== 8'h77) begin
            failures++;
            $display("FAIL ovf_flag: ovf=%b sent=%h required 1 77", o_rx_overflow, tx_log[dv0 % 64]);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (o_rx_empty !== 1'b0 || o_rd_byte !== 8'h10 + 8'(i)) begin
                failures++;
                $display("FAIL ovf_rx%0d: empty=%b byte=%h required 0 %h",
                         i, o_rx_empty, o_rd_byte, 8'h10 + 8'(i));
            end
            pop();
        end
        checks++;
        if (o_rx_empty !== 1'b1) begin
            failures++;
            $display("FAIL ovf_rx_count: empty=%b required 1 after 16 pops", o_rx_empty);
        end
    endtask

    task automatic test_start_while_busy();
        int dv0, done0, n;
        dv0 = n_dv; done0 = n_done;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        start(5'd1);
        start(5'd2);
        n = 0;
        while (!o_done && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (o_done !== 1'b1) begin
            failures++;
            $display("FAIL busy_done_wait: done=%b required 1", o_done);
        end
        start(5'd1);
        wait_idle("busy_idle");
        checks++;
        if (n_dv - dv0 != 1 || n_done - done0 != 1 || tx_log[dv0 % 64] !== 8'h11) begin
            failures++;
            $display("FAIL busy_ignored: dv=%0d done=%0d byte=%h required 1 1 11",
                     n_dv - dv0, n_done - done0, tx_log[dv0 % 64]);
        end
        start(5'd1);
        checks++;
        if (o_busy !== 1'b1 || o_spi_cs_n !== 1'b0) begin
            failures++;
            $display("FAIL busy_next_start: busy=%b cs_n=%b required 1 0", o_busy, o_spi_cs_n);
        end
        wait_idle("busy_idle2");
        checks++;
        if (n_dv - dv0 != 2 || tx_log[(dv0 + 1) % 64] !== 8'h22) begin
            failures++;
            $display("FAIL busy_second: dv=%0d byte=%h required 2 22",
                     n_dv - dv0, tx_log[(dv0 + 1) % 64]);
        end
        repeat (2) pop();
    endtask

    task automatic test_reset_mid();
        int seen, n, done0, dv0;
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        start(5'd4);
        seen = 0;
        n = 0;
        while (seen < 2 && n < 200) begin
            tick();
            if (o_m_tx_dv) seen++;
            n++;
        end
        checks++;
        if (seen != 2) begin
            failures++;
            $display("FAIL rst_reach_byte2: dv seen=%0d required 2", seen);
        end
        done0 = n_done;
        reset = 1'b1;
        tick();
        checks++;
        if ({o_spi_cs_n, o_busy, o_rx_empty, o_m_tx_dv, o_done} !== 5'b10100) begin
            failures++;
            $display("FAIL rst_mid_state: cs_n,busy,rx_empty,dv,done=%b required 10100",
                     {o_spi_cs_n, o_busy, o_rx_empty, o_m_tx_dv, o_done});
        end
        tick();
        reset = 1'b0;
        repeat (8) tick();
        checks++;
        if (n_done != done0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_done: done pulses=%0d busy=%b required 0 0",
                     n_done - done0, o_busy);
        end
        dv0 = n_dv;
        start(5'd1);
        wait_idle("rst_idle");
        checks++;
        if (tx_log[dv0 % 64] !== 8'h00 || o_underrun !== 1'b1) begin
            failures++;
            $display("FAIL rst_tx_discard: sent=%h ur=%b required 00 1", tx_log[dv0 % 64], o_underrun);
        end
        pop();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_bad_len();
        test_rx_overflow();
        test_start_while_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_txn_sequencer.md
Name: spi_txn_sequencer

Overview:
- Multi-byte SPI transaction controller directly upstream of the byte-level SPI master.
- Host side: pushes bytes into a TX FIFO, issues a start with a byte count, and pops received bytes from an RX FIFO.
- Master side: drives chip select with programmable setup, hold and idle gaps, and feeds the master one byte per handshake.
- Collects each returned MISO byte.

Parameters:
- FIFO_DEPTH, 16: depth of each of the TX and RX FIFOs; power of two, minimum 2.
- MAX_LEN, 16: largest byte count per transaction; must satisfy MAX_LEN <= FIFO_DEPTH.
- CS_SETUP_CLKS, 2: clk cycles from cs_n falling to the first byte dv; minimum 1.
- CS_HOLD_CLKS, 2: clk cycles from the last byte completing to cs_n rising; minimum 1.
- CS_IDLE_CLKS, 2: minimum clk cycles cs_n stays high before the next transaction; minimum 1.
- FILL_BYTE, 8'h00: byte sent when the TX FIFO underruns.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_wr_byte  in  8  TX FIFO write data
- i_wr_en  in  1  TX FIFO push; ignored when o_tx_full
- o_tx_full  out  1  TX FIFO full
- i_start  in  1  one-cycle transaction request
- i_len  in  LW  byte count, LW = $clog2(MAX_LEN+1)
- o_busy  out  1  transaction in progress, including the CS idle gap
- o_done  out  1  one-cycle pulse when cs_n rises
- o_underrun  out  1  sticky; cleared on accepted start
- o_rx_overflow  out  1  sticky; cleared on accepted start
- i_rd_en  in  1  RX FIFO pop; ignored when o_rx_empty
- o_rd_byte  out  8  RX FIFO head, first-word-fall-through
- o_rx_empty  out  1  RX FIFO empty
- o_m_tx_byte  out  8  byte to the SPI master
- o_m_tx_dv  out  1  one-cycle byte valid to the SPI master
- i_m_tx_ready  in  1  master idle
- i_m_rx_dv  in  1  master received-byte pulse
- i_m_rx_byte  in  8  master received byte
- o_spi_cs_n  out  1  active-low chip select

Behaviour:
- Reset values: all FIFOs empty; FSM in IDLE; o_spi_cs_n=1; o_m_tx_dv=0; o_m_tx_byte=0; o_busy=0; o_done=0; both sticky flags=0.
- Reset mid-transaction aborts immediately: cs_n=1 on the next edge, no o_done pulse, and the FIFO contents are discarded.
- FSM states: IDLE, SETUP, SEND, WAIT_RX, WAIT_RDY, HOLD, GAP.
- IDLE:
  - i_start with 1 <= i_len <= MAX_LEN: latch the length, clear the sticky flags, cs_n=0 on the next cycle, go to SETUP.
  - i_len=0 or i_len>MAX_LEN: start ignored, no state change.
  - i_start outside IDLE is ignored.
- SETUP: counts CS_SETUP_CLKS cycles, then goes to SEND.
- SEND:
  - Waits for i_m_tx_ready=1, then drives o_m_tx_dv=1 for exactly one cycle with o_m_tx_byte = TX FIFO head, and pops the TX FIFO.
  - If the TX FIFO is empty, sends FILL_BYTE without popping and sets o_underrun.
  - Goes to WAIT_RX.
- WAIT_RX:
  - i_m_tx_ready is ignored here, because the master deasserts ready one cycle after dv.
  - Waits for i_m_rx_dv, then pushes i_m_rx_byte into the RX FIFO.
  - If the RX FIFO is full, the byte is dropped and o_rx_overflow is set.
  - Decrements the remaining count, then goes to WAIT_RDY.
- WAIT_RDY: waits for i_m_tx_ready=1. Remaining count > 0 goes to SEND (dv issued the same cycle ready is seen); count = 0 goes to HOLD.
- HOLD: counts CS_HOLD_CLKS cycles, then cs_n=1, o_done pulses in that same cycle, and goes to GAP.
- GAP: counts CS_IDLE_CLKS cycles with o_busy=1, then goes to IDLE.
- o_busy=1 in every state except IDLE.
- Byte order: FIFO order; bit order within a byte is the master's (MSB first).
- FIFO concurrency:
  - Host push and pop are permitted during a transaction.
  - A simultaneous push and pop on a full or empty FIFO follows FIFO rules: a pop from empty is ignored; a push to full is ignored unless a pop occurs in the same cycle, in which case both succeed.
  - The counts use a wrap-around pointer plus an extra MSB.
- Output timing: o_m_tx_dv, o_m_tx_byte and o_spi_cs_n are registered.

Decomposition:
- Package spi_seq_pkg holds:
  - the state enumeration;
  - the LW width function;
  - the FILL_BYTE default.
- One sub-module, spi_sync_fifo (parameters WIDTH, DEPTH; FWFT; full, empty and count outputs), instantiated twice: TX and RX.

Test Plan:
- Push 8'hA5, 8'h3C; start with len=2; master model loops MOSI back to MISO -> two dv pulses carrying A5 then 3C; RX FIFO reads A5, 3C; cs_n low for setup + 2 bytes + hold; exactly one o_done; o_busy falls CS_IDLE_CLKS cycles after cs_n rises.
- Push 1 byte; start with len=3 -> bytes sent: byte, 00, 00; o_underrun=1 after o_done; the next accepted start clears it.
- Start with len=0, and separately len=MAX_LEN+1 -> cs_n stays 1, o_busy stays 0, no dv pulses.
- Fill the RX FIFO with 16 bytes unread; run a len=1 transaction -> rx byte dropped, o_rx_overflow=1, RX count stays 16.
- Issue i_start while busy, and a new start during GAP -> ignored; the following start only takes effect after o_busy=0.
- Assert reset during WAIT_RX of byte 2 of 4 -> the next cycle shows cs_n=1, FSM in IDLE, FIFOs empty, no o_done pulse.
